// File: rtl/fft_sched_pkg.sv
// Shared types and sizing helpers for the FFT frame sequencer.
package fft_sched_pkg;

  typedef enum logic [2:0] {
    LOAD_W,
    GATHER,
    ISSUE,
    WAIT,
    DRAIN
  } state_e;

  function automatic int frame_words(input int npoint);
    return 2 * (1 << npoint);
  endfunction

  function automatic int weight_words(input int npoint);
    return 2 * npoint * (1 << (npoint - 1));
  endfunction

  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/fft_frame_serializer.sv
// Holds one captured FFT result and streams it to the host as real/imag words,
// point 0 first; pulses done on the transfer of the last word.
module fft_frame_serializer
  import fft_sched_pkg::*;
#(
  parameter int NPOINT = 3,
  parameter int DW     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      active,
  input  logic [DW*(1<<NPOINT)-1:0] dout_real,
  input  logic [DW*(1<<NPOINT)-1:0] dout_imag,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DW-1:0]             out_data,
  output logic                      done
);

  localparam int N  = 1 << NPOINT;
  localparam int FW = frame_words(NPOINT);
  localparam int CW = $clog2(FW);

  logic [DW*N-1:0] buf_real_q, buf_real_d;
  logic [DW*N-1:0] buf_imag_q, buf_imag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last;
  int              lane;

  assign last      = (cnt_q == CW'(FW - 1));
  assign out_valid = active;
  assign done      = active && out_ready && last;

  always_comb begin
    buf_real_d = buf_real_q;
    buf_imag_d = buf_imag_q;
    cnt_d      = cnt_q;
    if (load) begin
      buf_real_d = dout_real;
      buf_imag_d = dout_imag;
      cnt_d      = '0;
    end else if (active && out_ready && !last) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Even drain index selects the real lane, odd the imag lane of the same point.
  always_comb begin
    lane     = int'(cnt_q >> 1);
    out_data = cnt_q[0] ? buf_imag_q[lane_lsb(lane, DW) +: DW]
                        : buf_real_q[lane_lsb(lane, DW) +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_real_q <= '0;
      buf_imag_q <= '0;
      cnt_q      <= '0;
    end else begin
      buf_real_q <= buf_real_d;
      buf_imag_q <= buf_imag_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Sequencer between host word streams and the FFT core: loads twiddle weights once,
// then loops gather -> issue -> wait -> drain with a single frame in flight.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int NPOINT = 3,
  parameter int DW     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data,
  output logic                      fft_weight_valid,
  output logic [DW-1:0]             fft_weight_real,
  output logic [DW-1:0]             fft_weight_imag,
  output logic                      fft_din_valid,
  input  logic                      fft_din_busy,
  output logic [DW*(1<<NPOINT)-1:0] fft_din_real,
  output logic [DW*(1<<NPOINT)-1:0] fft_din_imag,
  input  logic                      fft_dout_valid,
  output logic                      fft_dout_busy,
  input  logic [DW*(1<<NPOINT)-1:0] fft_dout_real,
  input  logic [DW*(1<<NPOINT)-1:0] fft_dout_imag,
  output logic                      weight_done
);

  localparam int N  = 1 << NPOINT;
  localparam int FW = frame_words(NPOINT);
  localparam int WW = weight_words(NPOINT);
  localparam int CW = $clog2((WW > FW) ? WW : FW);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   w_real_q, w_real_d, w_imag_q, w_imag_d;
  logic            w_valid_q, w_valid_d;
  logic            done_q, done_d;
  logic [DW*N-1:0] din_real_q, din_real_d, din_imag_q, din_imag_d;
  logic            in_fire, capture, drain_done;
  int              lane;

  // Handshake outputs come from the registered state only.
  assign in_ready      = (state_q == LOAD_W) || (state_q == GATHER);
  assign fft_din_valid = (state_q == ISSUE);
  assign fft_dout_busy = (state_q != WAIT);
  assign in_fire       = in_valid && in_ready;
  assign capture       = (state_q == WAIT) && fft_dout_valid;

  assign fft_weight_valid = w_valid_q;
  assign fft_weight_real  = w_real_q;
  assign fft_weight_imag  = w_imag_q;
  assign fft_din_real     = din_real_q;
  assign fft_din_imag     = din_imag_q;
  assign weight_done      = done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_real_d   = w_real_q;
    w_imag_d   = w_imag_q;
    w_valid_d  = 1'b0;
    done_d     = done_q;
    din_real_d = din_real_q;
    din_imag_d = din_imag_q;
    lane       = int'(cnt_q >> 1);
    case (state_q)
      LOAD_W: begin
        if (in_fire) begin
          if (cnt_q[0]) begin
            w_imag_d  = in_data;
            w_valid_d = 1'b1;
          end else begin
            w_real_d = in_data;
          end
          if (cnt_q == CW'(WW - 1)) begin
            state_d = GATHER;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GATHER: begin
        if (in_fire) begin
          if (cnt_q[0]) din_imag_d[lane_lsb(lane, DW) +: DW] = in_data;
          else          din_real_d[lane_lsb(lane, DW) +: DW] = in_data;
          if (cnt_q == CW'(FW - 1)) begin
            state_d = ISSUE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ISSUE:   if (!fft_din_busy) state_d = WAIT;
      WAIT:    if (fft_dout_valid) state_d = DRAIN;
      DRAIN: begin
        if (drain_done) begin
          state_d = GATHER;
          cnt_d   = '0;
        end
      end
      default: state_d = LOAD_W;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_W;
      cnt_q      <= '0;
      w_real_q   <= '0;
      w_imag_q   <= '0;
      w_valid_q  <= 1'b0;
      done_q     <= 1'b0;
      din_real_q <= '0;
      din_imag_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_real_q   <= w_real_d;
      w_imag_q   <= w_imag_d;
      w_valid_q  <= w_valid_d;
      done_q     <= done_d;
      din_real_q <= din_real_d;
      din_imag_q <= din_imag_d;
    end
  end

  fft_frame_serializer #(
    .NPOINT(NPOINT),
    .DW    (DW)
  ) u_serializer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .active   (state_q == DRAIN),
    .dout_real(fft_dout_real),
    .dout_imag(fft_dout_imag),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .done     (drain_done)
  );

endmodule

// File: tb/tb_fft_frame_sched.sv
// Randomized self-checking bench for fft_frame_sched: weight load, frame loop,
// handshake protection, stalled drain and reset in the middle of a drain.
module tb_fft_frame_sched;

  localparam int NPOINT = 3;
  localparam int DW     = 16;
  localparam int N      = 8;
  localparam int FW     = 16;
  localparam int WWORDS = 24;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid, out_ready;
  logic [DW-1:0]   out_data;
  logic            fft_weight_valid;
  logic [DW-1:0]   fft_weight_real, fft_weight_imag;
  logic            fft_din_valid, fft_din_busy;
  logic [DW*N-1:0] fft_din_real, fft_din_imag;
  logic            fft_dout_valid, fft_dout_busy;
  logic [DW*N-1:0] fft_dout_real, fft_dout_imag;
  logic            weight_done;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [DW-1:0] gw[FW];
  logic [DW-1:0] rr[N];
  logic [DW-1:0] ri[N];

  fft_frame_sched #(.NPOINT(NPOINT), .DW(DW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .fft_weight_valid(fft_weight_valid),
    .fft_weight_real (fft_weight_real),
    .fft_weight_imag (fft_weight_imag),
    .fft_din_valid   (fft_din_valid),
    .fft_din_busy    (fft_din_busy),
    .fft_din_real    (fft_din_real),
    .fft_din_imag    (fft_din_imag),
    .fft_dout_valid  (fft_dout_valid),
    .fft_dout_busy   (fft_dout_busy),
    .fft_dout_real   (fft_dout_real),
    .fft_dout_imag   (fft_dout_imag),
    .weight_done     (weight_done)
  );

  always #5 clk = ~clk;

  // Each one-cycle weight pulse is seen exactly once on the falling edge.
  always @(negedge clk) if (fft_weight_valid === 1'b1) pulses++;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*N-1:0] expDin(input int imag);
    logic [DW*N-1:0] r;
    for (int k = 0; k < N; k++) r[DW*k +: DW] = gw[2*k + imag];
    return r;
  endfunction

  task automatic checkResetValues();
    checkOutput("rst_in_ready",    256'(in_ready),         256'(1));
    checkOutput("rst_out_valid",   256'(out_valid),        256'(0));
    checkOutput("rst_out_data",    256'(out_data),         256'(0));
    checkOutput("rst_w_valid",     256'(fft_weight_valid), 256'(0));
    checkOutput("rst_w_real",      256'(fft_weight_real),  256'(0));
    checkOutput("rst_w_imag",      256'(fft_weight_imag),  256'(0));
    checkOutput("rst_din_valid",   256'(fft_din_valid),    256'(0));
    checkOutput("rst_din_real",    256'(fft_din_real),     256'(0));
    checkOutput("rst_din_imag",    256'(fft_din_imag),     256'(0));
    checkOutput("rst_dout_busy",   256'(fft_dout_busy),    256'(1));
    checkOutput("rst_weight_done", 256'(weight_done),      256'(0));
  endtask

  // Weight words carry value = index; pulse p must show real=2p, imag=2p+1.
  task automatic loadWeights();
    int p0;
    p0 = pulses;
    for (int i = 0; i < WWORDS; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = DW'(i);
      checkOutput("w_in_ready", 256'(in_ready), 256'(1));
      checkOutput("w_done_early", 256'(weight_done), 256'(0));
      tick();
      if (i % 2 == 1) begin
        checkOutput("w_pulse", 256'(fft_weight_valid), 256'(1));
        checkOutput("w_real", 256'(fft_weight_real), 256'(i - 1));
        checkOutput("w_imag", 256'(fft_weight_imag), 256'(i));
      end else begin
        checkOutput("w_no_pulse", 256'(fft_weight_valid), 256'(0));
      end
    end
    in_valid = 1'b0;
    checkOutput("w_done", 256'(weight_done), 256'(1));
    tick();
    checkOutput("w_pulse_count", 256'(pulses - p0), 256'(WWORDS / 2));
    checkOutput("w_done_sticky", 256'(weight_done), 256'(1));
  endtask

  task automatic gatherFrame(input int hold, input bit poke);
    fft_din_busy = (hold > 0);
    for (int i = 0; i < FW; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        if (poke) begin
          fft_dout_valid = 1'b1;
          fft_dout_real  = {$urandom, $urandom, $urandom, $urandom};
          checkOutput("gather_dout_busy", 256'(fft_dout_busy), 256'(1));
        end
        tick();
        fft_dout_valid = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = gw[i];
      checkOutput("gather_in_ready", 256'(in_ready), 256'(1));
      checkOutput("gather_din_valid", 256'(fft_din_valid), 256'(0));
      tick();
    end
    // Keep offering a junk word: it must never be consumed outside gather.
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    checkOutput("issue_valid", 256'(fft_din_valid), 256'(1));
    checkOutput("issue_in_ready", 256'(in_ready), 256'(0));
    checkOutput("issue_din_real", 256'(fft_din_real), 256'(expDin(0)));
    checkOutput("issue_din_imag", 256'(fft_din_imag), 256'(expDin(1)));
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput("hold_valid", 256'(fft_din_valid), 256'(1));
      checkOutput("hold_in_ready", 256'(in_ready), 256'(0));
      checkOutput("hold_din_real", 256'(fft_din_real), 256'(expDin(0)));
      checkOutput("hold_din_imag", 256'(fft_din_imag), 256'(expDin(1)));
    end
    fft_din_busy = 1'b0;
    tick();
    checkOutput("wait_dout_busy", 256'(fft_dout_busy), 256'(0));
    checkOutput("wait_din_valid", 256'(fft_din_valid), 256'(0));
    checkOutput("wait_in_ready", 256'(in_ready), 256'(0));
    checkOutput("wait_out_valid", 256'(out_valid), 256'(0));
  endtask

  // Returns after the whole frame drained, or after stopAfter words if stopAfter >= 0.
  task automatic drainFrame(input int stopAfter);
    logic [DW-1:0] q[$];
    int lat, got, target, budget;
    lat = $urandom_range(0, 3);
    repeat (lat) begin
      tick();
      checkOutput("lat_dout_busy", 256'(fft_dout_busy), 256'(0));
    end
    for (int k = 0; k < N; k++) begin
      fft_dout_real[DW*k +: DW] = rr[k];
      fft_dout_imag[DW*k +: DW] = ri[k];
    end
    fft_dout_valid = 1'b1;
    tick();
    fft_dout_valid = 1'b0;
    fft_dout_real  = {$urandom, $urandom, $urandom, $urandom};
    fft_dout_imag  = {$urandom, $urandom, $urandom, $urandom};
    checkOutput("drain_first_valid", 256'(out_valid), 256'(1));
    checkOutput("drain_first_data", 256'(out_data), 256'(rr[0]));
    checkOutput("drain_dout_busy", 256'(fft_dout_busy), 256'(1));
    checkOutput("drain_in_ready", 256'(in_ready), 256'(0));
    for (int k = 0; k < N; k++) begin
      q.push_back(rr[k]);
      q.push_back(ri[k]);
    end
    target = (stopAfter >= 0) ? stopAfter : FW;
    got    = 0;
    budget = 0;
    while (got < target && budget < 400) begin
      out_ready = ($urandom_range(0, 2) != 0);
      checkOutput("drain_valid", 256'(out_valid), 256'(1));
      if (out_ready) begin
        checkOutput("drain_data", 256'(out_data), 256'(q.pop_front()));
        got++;
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    checkOutput("drain_count", 256'(got), 256'(target));
    if (stopAfter < 0) begin
      checkOutput("post_drain_out_valid", 256'(out_valid), 256'(0));
      checkOutput("post_drain_in_ready", 256'(in_ready), 256'(1));
    end
  endtask

  task automatic randomFrame();
    for (int i = 0; i < FW; i++) gw[i] = DW'($urandom);
    for (int k = 0; k < N; k++) begin
      rr[k] = DW'($urandom);
      ri[k] = DW'($urandom);
    end
  endtask

  task automatic applyStimulus(input int hold, input bit poke, input int stopAfter);
    gatherFrame(hold, poke);
    drainFrame(stopAfter);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    out_ready      = 1'b0;
    fft_din_busy   = 1'b0;
    fft_dout_valid = 1'b0;
    fft_dout_real  = '0;
    fft_dout_imag  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    rst_n = 1'b1;
    tick();
    checkResetValues();

    loadWeights();

    for (int i = 0; i < FW; i++) gw[i] = DW'(16'h100 + i);
    for (int k = 0; k < N; k++) begin
      rr[k] = DW'(16'h200 + k);
      ri[k] = DW'(16'h300 + k);
    end
    applyStimulus(5, 1'b1, -1);

    for (int f = 0; f < 2; f++) begin
      randomFrame();
      applyStimulus($urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end

    randomFrame();
    applyStimulus(0, 1'b0, 6);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    checkResetValues();
    tick();
    rst_n = 1'b1;
    tick();
    checkResetValues();

    loadWeights();
    randomFrame();
    applyStimulus(1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Sequencer between the FX2 word streams and the FFT core. After reset it loads the twiddle weights from the host word stream. It then runs frames forever: gather one frame of complex samples, issue it to the core, capture the result, and serialize the result back to the host word stream. One frame is in flight at a time; the block owns every handshake toward the FFT core.

## Interface
- NPOINT, 3: log2 of FFT points; N = 2**NPOINT points per frame.
- DW, 16: sample/weight component width.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  host word available.
- in_ready  out  1  block accepts host word this cycle.
- in_data  in  DW  host word (weight or sample component).
- out_valid  out  1  result word available.
- out_ready  in  1  host writer accepts result word.
- out_data  out  DW  result word.
- fft_weight_valid  out  1  one-cycle pulse, weight pair valid.
- fft_weight_real / fft_weight_imag  out  DW each  current weight.
- fft_din_valid  out  1  frame offered to core.
- fft_din_busy  in  1  core cannot accept frame.
- fft_din_real / fft_din_imag  out  DW*N each  frame; point k at bits [DW*k+DW-1 : DW*k].
- fft_dout_valid  in  1  core result available.
- fft_dout_busy  out  1  block cannot accept result.
- fft_dout_real / fft_dout_imag  in  DW*N each  result, same packing.
- weight_done  out  1  all weights loaded; sticky until reset.

## Operation
- Word transfer: in_valid && in_ready; out_valid && out_ready; frame transfer: fft_din_valid && !fft_din_busy; result transfer: fft_dout_valid && !fft_dout_busy.
- Word order on both streams: real then imag, point 0 first. A frame is FW = 2*N words.
- Weight count W = NPOINT * 2**(NPOINT-1) complex weights, which is 2*W words. For NPOINT=3: 12 weights, 24 words.
- States:
  - LOAD_W: in_ready=1. An even word index latches fft_weight_real. An odd index latches fft_weight_imag, and fft_weight_valid pulses the next cycle. After the last word, weight_done goes to 1 and the state moves to GATHER.
  - GATHER: in_ready=1. Word 2k goes to real lane k; word 2k+1 goes to imag lane k. After word FW-1, the state moves to ISSUE.
  - ISSUE: fft_din_valid=1, with data held stable. On a frame transfer, the state moves to WAIT.
  - WAIT: fft_dout_busy=0. A result transfer captures both result buses into the output buffer; the state moves to DRAIN.
  - DRAIN: out_valid=1. out_data is the buffer word at the drain index. After word FW-1 is transferred, the state moves to GATHER.
- in_ready=0 in ISSUE, WAIT and DRAIN. Host words offered there are not consumed.
- fft_dout_busy=1 in every state except WAIT. Results offered outside WAIT are ignored.
- Word counters are sized for max(2*W, FW). Each counter clears on state entry. There is no wrap inside a state.
- The gather and drain buffers are separate registers. fft_din_* stays stable from ISSUE until the next gather overwrites it.

## Timing
- Reset values: state LOAD_W, all counters 0, in_ready=1, out_valid=0, out_data=0, fft_weight_valid=0, fft_weight_real/imag=0, fft_din_valid=0, fft_din_real/imag=0, fft_dout_busy=1, weight_done=0.
- in_ready, out_valid, fft_din_valid and fft_dout_busy decode combinationally from the registered state only. No input-to-output combinational path exists.
- fft_weight_valid rises exactly 1 cycle after the imag word is accepted, with the pair stable that cycle.
- Cycle after the last gather word: fft_din_valid=1. If fft_din_busy=0, the transfer completes that same cycle.
- Cycle after the result transfer: out_valid=1, out_data = real lane 0.
- Best-case loop, no stalls, N=8: 16 gather cycles, 1 issue cycle, core latency, 1 capture cycle, 16 drain cycles.
- If rst_n is asserted mid-operation, all state is lost and the block returns to LOAD_W. The host must resend the weights.

## Structure
- Package fft_sched_pkg holds:
  - the state enum (LOAD_W, GATHER, ISSUE, WAIT, DRAIN);
  - functions for frame_words(NPOINT) and weight_words(NPOINT);
  - the lane packing index helper.
- One sub-module, fft_frame_serializer, owns the drain buffer, drain counter and out_* handshake. It asserts a done pulse back to the main FSM.

## Test plan
- Weight load, NPOINT=3: feed words 0..23 with value = index. Expect 12 fft_weight_valid pulses. Pulse 0 carries real=0, imag=1; pulse 11 carries real=22, imag=23. weight_done rises after word 23.
- Gather/issue: feed words 0x100..0x10F. Expect fft_din_real lane k = 0x100+2k and fft_din_imag lane k = 0x101+2k. Hold fft_din_busy=1 for 5 cycles: fft_din_valid stays 1 and the data stays stable.
- Result drain: drive fft_dout_real lane k = 0x200+k and fft_dout_imag lane k = 0x300+k. Expect out_data sequence 0x200, 0x300, 0x201, 0x301, …, 0x207, 0x307.
  - Random out_ready stalls must not drop or duplicate words.
- Protection: assert in_valid during ISSUE, WAIT and DRAIN, and assert fft_dout_valid during GATHER. Expect in_ready=0, fft_dout_busy=1, and no state change.
- Back-to-back frames: run 3 frames with continuous in_valid. The 3 drained frames must match the 3 driven results, in order.
- Reset mid-DRAIN: after word 5, assert rst_n=0. Expect all outputs at reset values. weight_done=0 until 24 new weight words have been loaded.
